// File: rtl/serial_to_byte.sv
// serial_to_byte: serial-to-parallel frame assembler with a valid/ready output.
//
// Bits arrive LSB first on bit_in/bit_valid. Bit k of a frame lands in data bit k.
// When a frame completes, it is loaded into the output register. If that register is
// still held by the consumer, the frame is parked in a hold register instead. The block
// then stops taking bits (PENDING) until the consumer drains the output.
//
// Optional feature: define PARITY_CHECK_EN to extend each frame with a trailing
// even-parity bit. out_err is then the XOR of all WIDTH+1 received bits. Without the
// macro, frames are WIDTH bits and out_err is tied to 0.

module serial_to_byte #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [7:0]       frame_cnt
);

`ifdef PARITY_CHECK_EN
    // Data bits plus one trailing parity bit; every data bit goes through the shifter.
    localparam int unsigned FrameBits = WIDTH + 1;
    localparam int unsigned ShiftW    = WIDTH;
`else
    // The final data bit is taken straight from bit_in, so the shifter holds WIDTH-1 bits.
    localparam int unsigned FrameBits = WIDTH;
    localparam int unsigned ShiftW    = WIDTH - 1;
`endif

    localparam int unsigned   CntW    = $clog2(FrameBits);
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameBits - 1);

    typedef enum logic [0:0] {
        StShift,
        StPending
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [ShiftW-1:0]   shift_q;
    logic [ShiftW-1:0]   shift_d;
    logic [WIDTH-1:0]    hold_data_q;
    logic                hold_err_q;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic                out_err_q;
    logic [7:0]          frame_cnt_q;
`ifdef PARITY_CHECK_EN
    logic                par_q;
`endif

    logic                accept;
    logic                last_bit;
    logic                drain;
    logic [WIDTH-1:0]    frame_data;
    logic                frame_err;

    assign bit_ready = (state_q == StShift);
    assign accept    = bit_valid && bit_ready;
    assign last_bit  = accept && (cnt_q == LastIdx);
    assign drain     = out_valid_q && out_ready;

    // Right shifter: new bits enter at the top, so after all data bits bit k sits at index k.
    always_comb begin
        shift_d             = shift_q >> 1;
        shift_d[ShiftW-1]   = bit_in;
    end

    // Completed frame as it would be loaded on the edge that accepts the final bit.
    always_comb begin
`ifdef PARITY_CHECK_EN
        frame_data = shift_q;
        frame_err  = par_q ^ bit_in;
`else
        frame_data = {bit_in, shift_q};
        frame_err  = 1'b0;
`endif
    end

    // Bit collection, output register, hold register and frame counter in one FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StShift;
            cnt_q       <= '0;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
`ifdef PARITY_CHECK_EN
            par_q       <= 1'b0;
`endif
        end else begin
            // Bit counter and shifter advance only on accepted non-final bits.
            if (accept) begin
                if (last_bit) begin
                    cnt_q <= '0;
`ifdef PARITY_CHECK_EN
                    par_q <= 1'b0;
`endif
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                    shift_q <= shift_d;
`ifdef PARITY_CHECK_EN
                    par_q   <= par_q ^ bit_in;
`endif
                end
            end

            unique case (state_q)
                StShift: begin
                    if (last_bit && (!out_valid_q || out_ready)) begin
                        // Output free or being drained this edge: load directly.
                        out_data_q  <= frame_data;
                        out_err_q   <= frame_err;
                        out_valid_q <= 1'b1;
                    end else if (last_bit) begin
                        // Consumer stalled: park the frame and stop taking bits.
                        hold_data_q <= frame_data;
                        hold_err_q  <= frame_err;
                        state_q     <= StPending;
                    end else if (drain) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StPending: begin
                    // out_valid is always 1 here; a drain swaps in the parked frame.
                    if (drain) begin
                        out_data_q  <= hold_data_q;
                        out_err_q   <= hold_err_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StShift;
                    end
                end
                default: begin
                    state_q <= StShift;
                end
            endcase

            if (drain) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign frame_cnt = frame_cnt_q;

`ifndef SYNTHESIS
    // A parked frame implies the output register is occupied.
    pending_implies_valid: assert property (
        @(posedge clk) disable iff (rst) (state_q == StPending) |-> out_valid_q
    );

    // The bit counter never runs past the final frame bit.
    cnt_in_range: assert property (
        @(posedge clk) disable iff (rst) cnt_q <= LastIdx
    );
`endif

endmodule

// File: tb/tb_serial_to_byte.sv
// Bench for serial_to_byte. Frames are issued by a stimulus branch that pushes the expected
// {data, err} into a queue. A monitor branch pops and compares whenever a frame is handed
// over, and also tracks frame_cnt and output stability while the consumer stalls.
// Works with or without PARITY_CHECK_EN.

module tb_serial_to_byte;

    localparam int unsigned WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_valid;
    logic             bit_in;
    logic             bit_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic [7:0]       frame_cnt;

    always #5 clk = ~clk;

    serial_to_byte #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until an edge accepts it (bounded wait).
    task automatic send_bit(input logic b);
        int waited;
        waited    = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (!bit_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!bit_ready) begin
            checks++;
            errors++;
            $display("FAIL bit_ready_timeout: got bit_ready=0 for 200 cycles, expected 1");
        end
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Send one frame LSB first; gap idle cycles between bits; ready_last raises out_ready
    // in the cycle the final frame bit is presented.
    task automatic send_frame(input logic [7:0] data, input logic par, input int gap,
                              input bit ready_last);
        frame_t f;
        f.data = data;
        f.err  = PAR ? (^data ^ par) : 1'b0;
        exp_q.push_back(f);
        for (int k = 0; k < 8; k++) begin
            if (ready_last && !PAR && k == 7) out_ready = 1'b1;
            send_bit(data[k]);
            if (k < 7 || PAR) repeat (gap) tick();
        end
        if (PAR) begin
            if (ready_last) out_ready = 1'b1;
            send_bit(par);
        end
    endtask

    task automatic send_good(input logic [7:0] data, input int gap, input bit ready_last);
        logic p;
        p = ^data;
        send_frame(data, p, gap, ready_last);
    endtask

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will see.
    task automatic monitor();
        frame_t     f;
        logic [7:0] exp_cnt    = 8'd0;
        bit         prev_stall = 1'b0;
        bit         after_rst  = 1'b0;
        logic [7:0] prev_data  = 8'd0;
        logic       prev_err   = 1'b0;
        while (!done) begin
            @(negedge clk);
            check("frame_cnt", frame_cnt, exp_cnt);
            if (after_rst) check("out_valid_after_reset", out_valid, 0);
            if (prev_stall && out_valid) begin
                check("stall_data_stable", out_data, prev_data);
                check("stall_err_stable", out_err, prev_err);
            end
            if (rst) begin
                exp_cnt    = 8'd0;
                after_rst  = 1'b1;
                prev_stall = 1'b0;
            end else begin
                after_rst = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got data 0x%0h, expected none",
                                 out_data);
                    end else begin
                        f = exp_q.pop_front();
                        check("frame_data", out_data, f.data);
                        check("frame_err", out_err, f.err);
                    end
                    exp_cnt = exp_cnt + 8'd1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_err   = out_err;
            end
        end
    endtask

    task automatic stimulus();
        rst       = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_bit_ready", bit_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_err", out_err, 0);
        check("reset_frame_cnt", frame_cnt, 0);

        // 0xA5 back to back, consumer always ready: one cycle latency.
        out_ready = 1'b1;
        send_good(8'hA5, 0, 1'b0);
        check("a5_latency_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        tick();
        check("a5_frame_cnt", frame_cnt, 1);
        check("a5_drained", out_valid, 0);

        // Consumer stalled: second frame parks, bits blocked, then both delivered in order.
        out_ready = 1'b0;
        send_good(8'h3C, 0, 1'b0);
        check("3c_valid", out_valid, 1);
        send_good(8'hC3, 0, 1'b0);
        check("pending_bit_ready", bit_ready, 0);
        repeat (3) tick();
        check("pending_bit_ready_held", bit_ready, 0);
        check("pending_out_data", out_data, 8'h3C);
        out_ready = 1'b1;
        tick();
        check("c3_follows_valid", out_valid, 1);
        check("c3_follows_data", out_data, 8'hC3);
        check("c3_bit_ready", bit_ready, 1);
        tick();
        check("c3_drained", out_valid, 0);
        check("stall_frame_cnt", frame_cnt, 3);

        // Gaps between every bit.
        send_good(8'h5A, 1, 1'b0);
        check("5a_data", out_data, 8'h5A);
        tick();

        // Partial frame discarded by a reset pulse.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_bit_ready", bit_ready, 1);
        send_good(8'h0F, 0, 1'b0);
        check("0f_data", out_data, 8'h0F);
        tick();
        check("0f_frame_cnt", frame_cnt, 1);

        // Drain and load on the same edge.
        out_ready = 1'b0;
        send_good(8'h11, 0, 1'b0);
        send_good(8'h81, 0, 1'b1);
        check("81_valid", out_valid, 1);
        check("81_data", out_data, 8'h81);
        check("81_frame_cnt", frame_cnt, 2);
        tick();
        check("81_drained", out_valid, 0);
        check("81_frame_cnt_after", frame_cnt, 3);

`ifdef PARITY_CHECK_EN
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        check("parity_ok_err", out_err, 0);
        tick();
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        check("parity_bad_err", out_err, 1);
        tick();
`endif

        // Enough frames to wrap frame_cnt past 255.
        for (int i = 0; i < 260; i++) begin
            send_good(8'(i * 37 + 1), 0, 1'b0);
        end
        tick();
        check("wrap_frame_cnt", frame_cnt, PAR ? 8'd9 : 8'd7);
        repeat (2) tick();
        done = 1'b1;
    endtask

    initial begin
        fork
            stimulus();
            monitor();
            begin
                int cyc;
                cyc = 0;
                while (!done && cyc < 50000) begin
                    @(posedge clk);
                    cyc++;
                end
                if (!done) begin
                    $display("FAIL watchdog: got no completion after %0d cycles", cyc);
                    $fatal(1, "watchdog expired");
                end
            end
        join
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_byte.md
SERIAL_TO_BYTE -- requirements
Module: serial_to_byte

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per frame (WIDTH >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port bit_valid  input  1  bit_in carries a valid serial bit.
REQ-005 SHALL have port bit_in  input  1  serial data bit, LSB first.
REQ-006 SHALL have port bit_ready  output  1  block can accept a bit this cycle.
REQ-007 SHALL have port out_valid  output  1  out_data/out_err hold an unconsumed frame.
REQ-008 SHALL have port out_ready  input  1  consumer takes the frame this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  assembled frame data.
REQ-010 SHALL have port out_err  output  1  parity error flag for the frame in out_data.
REQ-011 SHALL have port frame_cnt  output  8  count of frames delivered to the consumer, wrapping.

Function
REQ-012 SHALL accept a bit on a rising edge only when bit_valid and bit_ready are both 1.
REQ-013 SHALL place the k-th accepted bit of a frame (k = 0..WIDTH-1) at data bit k.
REQ-014 SHALL implement states SHIFT (accepting bits) and PENDING (frame complete, output register occupied); bit_ready = 1 exactly in SHIFT.
REQ-015 SHALL, on acceptance of the final frame bit with the output register empty or being drained the same edge, load out_data/out_err, set out_valid, reset the bit count to 0 and stay in SHIFT.
REQ-016 SHALL, on acceptance of the final frame bit with out_valid=1 and out_ready=0, go to PENDING and hold the completed frame internally.
REQ-017 SHALL, in PENDING, on out_valid and out_ready both 1, load the held frame into the output register (out_valid stays 1) and return to SHIFT with count 0.
REQ-018 SHALL have latency of one cycle: out_valid high in the cycle after the edge that accepted the final bit (non-PENDING case).
REQ-019 SHALL clear out_valid when out_ready=1 and no new frame loads on the same edge; a simultaneous drain and load SHALL keep out_valid=1 with the new frame.
REQ-020 SHALL keep out_data, out_err stable while out_valid=1 and out_ready=0.
REQ-021 SHALL increment frame_cnt by 1 on each edge where out_valid and out_ready are both 1, wrapping 255 -> 0.
REQ-022 SHALL tolerate arbitrary gaps in bit_valid mid-frame without losing or reordering bits.

Reset
REQ-023 SHALL, on any edge with rst=1, set state SHIFT, bit count 0, shift register 0, out_valid 0, out_data 0, out_err 0, frame_cnt 0, discarding any partial or pending frame.
REQ-024 SHALL give bit_ready = 1 in the first cycle after rst deasserts; no bit is accepted on an edge with rst=1.

Configuration
REQ-025 SHALL, with PARITY_CHECK_EN defined, use a frame of WIDTH+1 bits, the last being an even-parity bit, and set out_err = XOR of all WIDTH+1 bits, loaded with out_data.
REQ-026 SHALL, without PARITY_CHECK_EN, use a frame of WIDTH bits and drive out_err constant 0.

Verification
REQ-027 SHALL cover: WIDTH=8, out_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> out_valid=1 one cycle after last bit, out_data=0xA5, frame_cnt 0->1.
REQ-028 SHALL cover: out_ready=0, send 0x3C then 0xC3 -> bit_ready=0 after 0xC3's last bit; raise out_ready -> 0x3C then 0xC3 delivered on consecutive cycles, bit_ready=1 again, frame_cnt=2.
REQ-029 SHALL cover: 0x5A sent with bit_valid toggling 1,0 every cycle -> out_data=0x5A.
REQ-030 SHALL cover: 4 bits of a frame accepted, rst pulsed one cycle, then 0x0F sent -> out_data=0x0F, out_valid=0 and frame_cnt=0 during/after reset.
REQ-031 SHALL cover: out_valid=1 with out_ready=1 on the edge accepting the next frame's last bit (0x81) -> out_valid stays 1, out_data=0x81, frame_cnt increments once.
REQ-032 SHALL cover, with PARITY_CHECK_EN: 0xA5 plus parity 0 -> out_err=0; 0xA5 plus parity 1 -> out_err=1.
